// File: rtl/filter_pkg.sv
// Shared definitions for the EMA filter: coefficient format and FSM state encoding.
package filter_pkg;

  localparam int unsigned COEF_W          = 8;
  localparam int unsigned COEF_FULL_SCALE = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } ema_state_e;

endpackage

// File: rtl/ema_filter_if.sv
// Sample stream bundle for ema_filter.
//   coefficient : smoothing weight, sampled together with in_data
//   clear       : synchronous re-prime request
//   in_valid / in_ready / in_data    : input sample handshake
//   out_valid / out_ready / out_data : filtered sample handshake
// master = sample producer / result consumer, slave = the filter.
interface ema_filter_if #(
  parameter int unsigned DATA_W = 12
);
  import filter_pkg::*;

  logic [COEF_W-1:0] coefficient;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output coefficient, clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  coefficient, clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/ema_datapath.sv
// Combinational EMA update: y_next = (c*y + (256-c)*x + R) >> 8, or x when not primed.
//   y       : current filter state
//   x       : latched sample
//   c       : latched coefficient
//   primed  : 0 on the first sample after reset/clear (output passes x through)
//   y_next  : next filter state
// Build option: EMA_ROUND_EN defined -> R = half LSB (round half up), else R = 0 (truncate).
module ema_datapath
  import filter_pkg::*;
#(
  parameter int unsigned DATA_W = 12
) (
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] x,
  input  logic [COEF_W-1:0] c,
  input  logic              primed,
  output logic [DATA_W-1:0] y_next
);

  localparam int unsigned ACC_W  = DATA_W + 9;
  localparam int unsigned CINV_W = COEF_W + 1;
  localparam int unsigned SHIFT  = $clog2(COEF_FULL_SCALE);

`ifdef EMA_ROUND_EN
  localparam logic [ACC_W-1:0] RND = ACC_W'(COEF_FULL_SCALE / 2);
`else
  localparam logic [ACC_W-1:0] RND = '0;
`endif

  logic [CINV_W-1:0] c_inv;
  logic [ACC_W-1:0]  acc;

  // Weights sum to full scale, so acc >> SHIFT is bounded by the larger of x and y.
  always_comb begin
    c_inv  = CINV_W'(COEF_FULL_SCALE) - CINV_W'(c);
    acc    = ACC_W'(c) * ACC_W'(y) + ACC_W'(c_inv) * ACC_W'(x) + RND;
    y_next = primed ? DATA_W'(acc >> SHIFT) : x;
  end

endmodule

// File: rtl/ema_filter.sv
// Exponential moving average filter with a valid/ready sample stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ema_filter_if.slave (coefficient, clear, in_*/out_* handshakes)
// One sample at a time: IDLE accepts, CALC updates the state, HOLD presents the
// result until taken. clear re-primes the filter and drops anything in flight.
// Build option: EMA_ROUND_EN selects round-half-up instead of truncation.
module ema_filter
  import filter_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned COEF_W = filter_pkg::COEF_W
) (
  input  logic           clk,
  input  logic           rst_n,
  ema_filter_if.slave    bus
);

  ema_state_e        state, state_next;
  logic [DATA_W-1:0] y;
  logic [DATA_W-1:0] y_next;
  logic [DATA_W-1:0] x_lat;
  logic [COEF_W-1:0] c_lat;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q, out_valid_next;
  logic              in_ready_q, in_ready_next;
  logic              primed, primed_next;
  logic              accept_c;
  logic              load_c;

  // Next-state and update strobes; clear overrides every transition.
  always_comb begin
    state_next     = state;
    out_valid_next = out_valid_q;
    primed_next    = primed;
    accept_c       = 1'b0;
    load_c         = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          accept_c   = 1'b1;
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        load_c         = 1'b1;
        out_valid_next = 1'b1;
        primed_next    = 1'b1;
        state_next     = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (bus.clear) begin
      accept_c       = 1'b0;
      load_c         = 1'b0;
      out_valid_next = 1'b0;
      primed_next    = 1'b0;
      state_next     = ST_IDLE;
    end

    // Registered ready tracks the state we are entering, so it is low in reset.
    in_ready_next = (state_next == ST_IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Sample latch, filter state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_lat       <= '0;
      c_lat       <= '0;
      y           <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      primed      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_next;
      in_ready_q  <= in_ready_next;
      primed      <= primed_next;
      if (accept_c) begin
        x_lat <= bus.in_data;
        c_lat <= COEF_W'(bus.coefficient);
      end
      if (load_c) begin
        y          <= y_next;
        out_data_q <= y_next;
      end
    end
  end

  ema_datapath #(
    .DATA_W (DATA_W)
  ) u_datapath (
    .y      (y),
    .x      (x_lat),
    .c      (filter_pkg::COEF_W'(c_lat)),
    .primed (primed),
    .y_next (y_next)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: doc/ema_filter.md
EMA_FILTER -- requirements
Module: ema_filter

Interface
REQ-001 SHALL have parameter DATA_W, default 12: unsigned sample width.
REQ-002 SHALL have parameter COEF_W, fixed at 8: smoothing coefficient width, full scale 256.
REQ-003 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port coefficient, input, 8: smoothing weight, 0 = pure input, 255 = maximum smoothing; driven by the coefficient mapper.
REQ-006 SHALL have port clear, input, 1: synchronous re-prime request.
REQ-007 SHALL have port in_valid, input, 1: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1: the block accepts a sample.
REQ-009 SHALL have port in_data, input, DATA_W: raw sample.
REQ-010 SHALL have port out_valid, output, 1: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1: the downstream consumer accepts out_data.
REQ-012 SHALL have port out_data, output, DATA_W: filtered sample.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, CALC, HOLD.
REQ-014 SHALL assert in_ready only in IDLE; in IDLE with in_valid=1, SHALL latch in_data and coefficient, then go to CALC.
REQ-015 SHALL, in CALC, compute y_next, load y_next into both the state register y and out_data, set out_valid=1, then go to HOLD.
REQ-016 SHALL hold out_valid and out_data stable in HOLD until out_ready=1, then clear out_valid and return to IDLE in the same edge.
REQ-017 SHALL give a latency of 2 clocks from input handshake to out_valid; minimum initiation interval 3 clocks.
REQ-018 SHALL compute y_next = (c*y + (256-c)*x + R) >> 8, where c is the latched coefficient and x is the latched sample.
REQ-019 SHALL size the accumulator at DATA_W+9 bits unsigned; the result SHALL never exceed 2^DATA_W-1, so no saturation is needed.
REQ-020 SHALL use the latched coefficient only; coefficient changes in CALC or HOLD SHALL NOT affect the sample in flight.
REQ-021 SHALL, on the first sample after reset or clear (primed=0), set y_next = x exactly, then set primed=1.
REQ-022 SHALL, on clear=1 in any state, clear primed, clear out_valid and go to IDLE; any sample in flight is dropped.
REQ-023 SHALL give clear priority when clear and in_valid are both high in IDLE: the sample is not accepted.

Reset
REQ-024 SHALL, on rst_n low, go to IDLE asynchronously and set y=0, out_data=0, out_valid=0, primed=0 and the latched values to 0.
REQ-025 SHALL hold in_ready low while rst_n is low.
REQ-026 SHALL, on reset mid-CALC or mid-HOLD, drop the sample with no output.

Configuration
REQ-027 SHALL, with EMA_ROUND_EN defined, use R=128 (round half up).
REQ-028 SHALL, without EMA_ROUND_EN defined, use R=0 (truncate); all other behaviour is identical.

Structure
REQ-029 SHALL take COEF_W, COEF_FULL_SCALE=256 and the FSM state enum from shared package filter_pkg.
REQ-030 SHALL place the multiply-accumulate-shift in one sub-module, ema_datapath: purely combinational, inputs y, x, c and primed, output y_next.

Verification
REQ-031 SHALL be verified by: reset then first sample x=1000, c=128 -> out_data=1000 two clocks after handshake.
REQ-032 SHALL be verified by: y=1000, c=0, x=300 -> out_data=300.
REQ-033 SHALL be verified by: y=1001, c=128, x=0 -> out_data=501 with EMA_ROUND_EN, 500 without.
REQ-034 SHALL be verified by: y=1000, c=255, x=0 -> out_data=996; coefficient changed to 0 during CALC -> still 996.
REQ-035 SHALL be verified by: out_ready held low 5 clocks in HOLD -> out_data stable, in_ready=0, no second sample accepted.
REQ-036 SHALL be verified by: clear asserted in HOLD, then x=40 -> out_valid drops, next output=40 (re-primed).
